// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the buffered 8N1 UART transmitter.
//
// Contents:
//   uart_tx_state_t            bit-timing FSM states
//   UART_TX_DEFAULT_CLOCK_DIV  system clocks per bit (86.4 MHz / 115200)
//   UART_TX_DATA_BITS          payload bits per frame
//   UART_TX_FRAME_BITS         start + data + stop bits per frame
//   uart_tx_frame_cycles()     frame length in system clocks for a divider
package uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    localparam int UART_TX_DEFAULT_CLOCK_DIV = 750;
    localparam int UART_TX_DATA_BITS         = 8;
    localparam int UART_TX_FRAME_BITS        = 10;

    function automatic int uart_tx_frame_cycles(input int clock_div);
        return UART_TX_FRAME_BITS * clock_div;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock byte FIFO feeding the UART serialiser.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high; empties the FIFO
//   push       write push_data (ignored while full)
//   push_data  byte to store
//   pop        advance the read pointer (ignored while empty)
//   head_data  oldest stored byte, combinational from the array
//   empty      count == 0
//   full       count == 2^DEPTH_LOG2
//   count      number of stored bytes
module uart_tx_fifo
    import uart_tx_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [7:0]            push_data,
    input  logic                  pop,
    output logic [7:0]            head_data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int                    DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty     = (count == '0);
    assign full      = (count == CNT_FULL);
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_data = mem[rd_ptr];

    // Storage carries no reset; stale entries are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are exactly DEPTH_LOG2 bits wide, so they wrap on their own.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: bytes enter a FIFO through a valid/ready
// handshake and are serialised LSB first, one start bit, eight data bits,
// one stop bit, each bit CLOCK_DIV system clocks long.
//
// Ports:
//   clk         system clock (only clock used)
//   reset       synchronous, active-high
//   send_req    a byte is offered on send_data
//   send_data   byte to transmit
//   send_ready  FIFO not full; byte accepted on send_req & send_ready
//   fifo_count  bytes waiting in the FIFO (excludes the byte being shifted)
//   busy        a frame is on the line or the FIFO holds data
//   uart_tx     serial line, idle high, driven straight from a flop
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | line high, waiting for the FIFO to hold a byte
// START | start bit (0) on the line for CLOCK_DIV cycles
// DATA  | shift[0] on the line, eight bits LSB first
// STOP  | stop bit (1); then pop the next byte or return to IDLE
module uart_tx_buffered
    import uart_tx_pkg::*;
#(
    parameter int CLOCK_DIV       = UART_TX_DEFAULT_CLOCK_DIV,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       send_req,
    input  logic [7:0]                 send_data,
    output logic                       send_ready,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_count,
    output logic                       busy,
    output logic                       uart_tx
);

    localparam logic [15:0] DIV_RELOAD = 16'(CLOCK_DIV - 1);
    localparam logic [2:0]  LAST_BIT   = 3'(UART_TX_DATA_BITS - 1);

    uart_tx_state_t state_q, state_d;
    logic [15:0]    div_q, div_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shift_q, shift_d;
    logic           tx_q, tx_d;

    logic           fifo_push;
    logic           fifo_pop;
    logic [7:0]     fifo_head;
    logic           fifo_empty;
    logic           fifo_full;
    logic           bit_end;

    // Ready comes from the registered count only, so a pop in this cycle
    // does not open a slot for a write in this cycle.
    assign send_ready = ~fifo_full;
    assign fifo_push  = send_req & send_ready;
    assign busy       = (state_q != IDLE) | (fifo_count != '0);
    assign uart_tx    = tx_q;
    assign bit_end    = (div_q == 16'd0);

    uart_tx_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (send_data),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // tx_d always carries the level for the *next* cycle, so each transition
    // below loads the value the line must show once the new state begins.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        fifo_pop = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    tx_d     = 1'b0;
                    div_d    = DIV_RELOAD;
                    state_d  = START;
                end
            end

            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                    div_d   = DIV_RELOAD;
                    tx_d    = shift_q[0];
                end else begin
                    div_d = div_q - 16'd1;
                end
            end

            DATA: begin
                if (bit_end) begin
                    div_d = DIV_RELOAD;
                    if (bit_q == LAST_BIT) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    div_d = div_q - 16'd1;
                end
            end

            STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        // Chain straight into the next start bit: no idle gap.
                        fifo_pop = 1'b1;
                        shift_d  = fifo_head;
                        tx_d     = 1'b0;
                        div_d    = DIV_RELOAD;
                        state_d  = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    div_d = div_q - 16'd1;
                end
            end

            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: a small instance (CLOCK_DIV=4, 4-entry FIFO)
// with a line decoder, and a default-parameter instance for the 750-cycle bit.
module tb_uart_tx_buffered;

    localparam int S_DIV   = 4;
    localparam int D_DIV   = 750;
    localparam int S_FRAME = 10 * S_DIV;

    logic clk = 1'b0;
    int   cyc = 0;

    logic       s_reset, s_req, s_ready, s_busy, s_tx;
    logic [7:0] s_data;
    logic [2:0] s_count;

    logic       d_reset, d_req, d_ready, d_busy, d_tx;
    logic [7:0] d_data;
    logic [4:0] d_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] s_exp_q[$];
    int         s_fall_q[$];
    logic [7:0] d_exp_q[$];

    uart_tx_buffered #(
        .CLOCK_DIV       (S_DIV),
        .FIFO_DEPTH_LOG2 (2)
    ) u_dut_s (
        .clk        (clk),
        .reset      (s_reset),
        .send_req   (s_req),
        .send_data  (s_data),
        .send_ready (s_ready),
        .fifo_count (s_count),
        .busy       (s_busy),
        .uart_tx    (s_tx)
    );

    uart_tx_buffered u_dut_d (
        .clk        (clk),
        .reset      (d_reset),
        .send_req   (d_req),
        .send_data  (d_data),
        .send_ready (d_ready),
        .fifo_count (d_count),
        .busy       (d_busy),
        .uart_tx    (d_tx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Line decoder for the small instance; frame timing is taken from the
    // falling edge of the start bit, bits sampled mid-period.
    initial begin : s_monitor
        bit         busy_m;
        bit         unstable;
        logic       cur;
        logic [9:0] bits;
        int         k;
        busy_m = 0;
        unstable = 0;
        cur = 1'b1;
        bits = '0;
        k = 0;
        forever begin
            @(negedge clk);
            if (s_reset) begin
                busy_m = 0;
                s_exp_q.delete();
            end else if (!busy_m) begin
                if (s_tx == 1'b0) begin
                    busy_m = 1;
                    k = 0;
                    unstable = 0;
                    cur = 1'b0;
                    s_fall_q.push_back(cyc);
                end
            end else begin
                k++;
                if (k % S_DIV == 0) cur = s_tx;
                else if (s_tx !== cur) unstable = 1;
                if (k % S_DIV == S_DIV / 2) bits[k / S_DIV] = s_tx;
                if (k == S_FRAME - 1) begin
                    busy_m = 0;
                    check_eq("start_bit", 32'(bits[0]), 32'd0);
                    check_eq("stop_bit", 32'(bits[9]), 32'd1);
                    check_eq("bit_stable", 32'(unstable), 32'd0);
                    check_eq("frame_expected", 32'(s_exp_q.size() != 0), 32'd1);
                    if (s_exp_q.size() != 0) begin
                        check_eq("rx_byte", 32'(bits[8:1]), 32'(s_exp_q.pop_front()));
                    end
                end
            end
        end
    end

    // Offer one byte and keep it on send_data until ready is seen; returns
    // one negedge after the accepting edge with send_req low.
    task automatic s_push(input logic [7:0] b);
        int t;
        t = 0;
        s_req = 1'b1;
        s_data = b;
        while (!s_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        check_eq("push_accepted", 32'(s_ready), 32'd1);
        if (s_ready) s_exp_q.push_back(b);
        @(negedge clk);
        s_req = 1'b0;
    endtask

    task automatic s_wait_idle(input int limit, output int t_idle);
        int t;
        t = 0;
        while (s_busy && t < limit) begin
            @(negedge clk);
            t++;
        end
        check_eq("idle_reached", 32'(s_busy), 32'd0);
        t_idle = cyc;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: bench still running at cycle %0d, want finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int t_req, t_idle, fall, rise, t;
        bit first_stall, done, seen_rise, low_seen;
        logic [9:0] dbits;

        s_reset = 1'b1; s_req = 1'b0; s_data = '0;
        d_reset = 1'b1; d_req = 1'b0; d_data = '0;
        repeat (2) @(negedge clk);

        check_eq("reset_tx", 32'(s_tx), 32'd1);
        check_eq("reset_ready", 32'(s_ready), 32'd1);
        check_eq("reset_count", 32'(s_count), 32'd0);
        check_eq("reset_busy", 32'(s_busy), 32'd0);
        check_eq("reset_tx_dflt", 32'(d_tx), 32'd1);
        check_eq("reset_count_dflt", 32'(d_count), 32'd0);
        s_reset = 1'b0;
        d_reset = 1'b0;
        repeat (3) @(negedge clk);

        // single byte 0x55
        s_fall_q.delete();
        t_req = cyc;
        s_push(8'h55);
        check_eq("count_after_push", 32'(s_count), 32'd1);
        check_eq("tx_before_start", 32'(s_tx), 32'd1);
        s_wait_idle(200, t_idle);
        check_eq("single_frames", 32'(s_fall_q.size()), 32'd1);
        if (s_fall_q.size() == 1) begin
            check_eq("start_latency", 32'(s_fall_q[0] - t_req), 32'd2);
            check_eq("busy_drop", 32'(t_idle - s_fall_q[0]), 32'(S_FRAME));
        end
        repeat (5) @(negedge clk);

        // back-to-back 0xA5, 0x3C
        s_fall_q.delete();
        s_push(8'hA5);
        s_push(8'h3C);
        s_wait_idle(300, t_idle);
        check_eq("b2b_frames", 32'(s_fall_q.size()), 32'd2);
        if (s_fall_q.size() == 2) check_eq("b2b_gap", 32'(s_fall_q[1] - s_fall_q[0]), 32'(S_FRAME));
        check_eq("b2b_drained", 32'(s_exp_q.size()), 32'd0);
        repeat (5) @(negedge clk);

        // full FIFO: req held high, data 0x00.., garbage shown while stalled
        s_fall_q.delete();
        first_stall = 1;
        s_req = 1'b1;
        for (int d = 0; d < 8; d++) begin
            done = 0;
            t = 0;
            while (!done && t < 400) begin
                if (s_ready) begin
                    s_data = 8'(d);
                    s_exp_q.push_back(8'(d));
                    done = 1;
                end else begin
                    if (first_stall) begin
                        check_eq("count_at_stall", 32'(s_count), 32'd4);
                        check_eq("accepted_before_stall", 32'(d), 32'd5);
                        first_stall = 0;
                    end
                    s_data = 8'hEE;
                    @(negedge clk);
                    t++;
                end
            end
            check_eq("full_push_accepted", 32'(done), 32'd1);
            @(negedge clk);
        end
        s_req = 1'b0;
        s_wait_idle(600, t_idle);
        check_eq("full_frames", 32'(s_fall_q.size()), 32'd8);
        if (s_fall_q.size() == 8) check_eq("full_span", 32'(s_fall_q[7] - s_fall_q[0]), 32'(7 * S_FRAME));
        check_eq("full_drained", 32'(s_exp_q.size()), 32'd0);
        repeat (5) @(negedge clk);

        // reset during data bit 3 with two bytes queued
        s_fall_q.delete();
        s_push(8'h96);
        s_push(8'h0F);
        s_push(8'hC3);
        t = 0;
        while (s_fall_q.size() == 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_eq("rst_frame_started", 32'(s_fall_q.size()), 32'd1);
        fall = (s_fall_q.size() != 0) ? s_fall_q[0] : cyc;
        while (cyc < fall + 4 * S_DIV + 1) @(negedge clk);
        check_eq("queued_before_reset", 32'(s_count), 32'd2);
        s_reset = 1'b1;
        @(negedge clk);
        check_eq("rst_tx", 32'(s_tx), 32'd1);
        check_eq("rst_count", 32'(s_count), 32'd0);
        check_eq("rst_busy", 32'(s_busy), 32'd0);
        check_eq("rst_ready", 32'(s_ready), 32'd1);
        @(negedge clk);
        s_reset = 1'b0;
        s_fall_q.delete();
        low_seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (s_tx !== 1'b1) low_seen = 1;
        end
        check_eq("no_resume_low", 32'(low_seen), 32'd0);
        check_eq("no_resume_frames", 32'(s_fall_q.size()), 32'd0);
        s_push(8'h5A);
        s_wait_idle(200, t_idle);
        check_eq("post_rst_frames", 32'(s_fall_q.size()), 32'd1);
        check_eq("post_rst_drained", 32'(s_exp_q.size()), 32'd0);

        // default parameters: 0x41, 750-cycle bits
        check_eq("dflt_ready", 32'(d_ready), 32'd1);
        t_req = cyc;
        d_req = 1'b1;
        d_data = 8'h41;
        d_exp_q.push_back(8'h41);
        @(negedge clk);
        d_req = 1'b0;
        t = 0;
        while (d_tx && t < 10) begin
            @(negedge clk);
            t++;
        end
        check_eq("dflt_start_seen", 32'(d_tx), 32'd0);
        fall = cyc;
        check_eq("dflt_latency", 32'(fall - t_req), 32'd2);
        seen_rise = 0;
        rise = fall;
        dbits = '1;
        t = 0;
        while (d_busy && t < 8000) begin
            if ((cyc - fall) % D_DIV == D_DIV / 2 && (cyc - fall) / D_DIV < 10)
                dbits[(cyc - fall) / D_DIV] = d_tx;
            if (!seen_rise && d_tx) begin
                seen_rise = 1;
                rise = cyc;
            end
            @(negedge clk);
            t++;
        end
        check_eq("dflt_idle", 32'(d_busy), 32'd0);
        check_eq("dflt_bit_period", 32'(rise - fall), 32'(D_DIV));
        check_eq("dflt_frame_len", 32'(cyc - fall), 32'(10 * D_DIV));
        check_eq("dflt_start_bit", 32'(dbits[0]), 32'd0);
        check_eq("dflt_stop_bit", 32'(dbits[9]), 32'd1);
        check_eq("dflt_byte", 32'(dbits[8:1]), 32'(d_exp_q.pop_front()));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Buffered 8N1 UART transmitter driving the board's `uart_tx` pin (PIN69_SYS_TX) from the system clock domain. Internal logic pushes bytes through a valid/ready handshake into a small FIFO. A bit-timing state machine serialises the bytes LSB first at a fixed divider-derived baud rate. This block is the final stage before the `uart_tx` top-level output.

## Interface
- `CLOCK_DIV`, default 750: system clocks per bit (86.4 MHz / 115200). Legal range is 2..65535.
- `FIFO_DEPTH_LOG2`, default 4: FIFO holds 2^N bytes. Legal range is 1..8.
- `clk`, input, 1: system clock. The block uses this single clock only.
- `reset`, input, 1: synchronous, active-high reset.
- `send_req`, input, 1: a byte is offered on `send_data`.
- `send_data`, input, 8: the byte to transmit.
- `send_ready`, output, 1: FIFO not full. A byte is accepted when `send_req & send_ready`.
- `fifo_count`, output, FIFO_DEPTH_LOG2+1: number of bytes stored in the FIFO. This excludes the byte being shifted.
- `busy`, output, 1: high while a frame is on the line or the FIFO is non-empty.
- `uart_tx`, output, 1: serial line. Idle level is high.

## Operation
- Reset values: `uart_tx`=1, `send_ready`=1, `fifo_count`=0, `busy`=0. FSM goes to IDLE, FIFO pointers go to 0, bit counter and divider counter go to 0.
- FIFO write happens on `send_req & send_ready`. When full, `send_req` is ignored and the data is dropped. The producer must hold the byte until it sees ready.
- `send_ready` is combinational `~full`, derived from the registered count. A pop in the same cycle does not make room for a write in that cycle.
- A simultaneous push and pop leaves `fifo_count` unchanged. Pointers wrap modulo 2^FIFO_DEPTH_LOG2.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE with FIFO non-empty: pop the head into the shift register, drive `uart_tx`=0, go to START, load the divider.
  - START: hold 0 for CLOCK_DIV cycles, then go to DATA with bit index 0.
  - DATA: drive `shift[0]`, shift right every CLOCK_DIV cycles, and run 8 bits. After bit 7, go to STOP.
  - STOP: drive 1 for CLOCK_DIV cycles.
  - End of STOP with FIFO non-empty: pop the next byte and go directly to START. There is no idle gap between frames.
  - End of STOP with FIFO empty: go to IDLE.
- The frame is always 10 × CLOCK_DIV cycles: start bit, 8 data bits LSB first, 1 stop bit. There is no parity.
- `busy` = (state != IDLE) | (fifo_count != 0).
- Reset mid-frame: the line returns to 1 on the next cycle, FIFO contents are discarded, and no partial frame resumes.

## Timing
- Cycle N: handshake accepted. Cycle N+1: `fifo_count` increments.
- Cycle N+1, FSM in IDLE: the pop is registered. `uart_tx` falls at the N+2 edge, giving write-to-start-bit latency of 2 cycles.
- Each bit lasts exactly CLOCK_DIV cycles. The divider is a down-counter reloaded to CLOCK_DIV-1 at each bit boundary.
- `uart_tx` is driven directly from a flop so the pin is glitch-free.
- Back-to-back frames: the falling edge of the next start bit comes exactly 10×CLOCK_DIV cycles after the previous one.

## Structure
- Package `uart_tx_pkg`:
  - state enum `uart_tx_state_t` (IDLE, START, DATA, STOP)
  - `localparam` default divider 750
  - frame length constant 10
- Sub-module `uart_tx_fifo`: synchronous single-clock FIFO.
  - Parameter: depth.
  - Ports: push, push_data, pop, head_data, empty, full, count.
  - Head data is combinational from the RAM array.
- The top module holds the FSM, divider counter, bit counter and shift register.

## Test plan
- Single byte: CLOCK_DIV=4, reset, then push 0x55. Required response:
  - `uart_tx` falls 2 cycles later.
  - Line reads 0,1,0,1,0,1,0,1,0,1, each held 4 cycles.
  - `busy` drops 40 cycles after the start bit.
- Back-to-back: push 0xA5 and 0x3C on consecutive cycles. Required response:
  - Frames are contiguous, with the second start bit exactly 40 cycles after the first.
  - Decoded bytes are 0xA5 then 0x3C.
- Full FIFO: FIFO_DEPTH_LOG2=2 and `send_req` held high with incrementing data 0x00.. Required response:
  - `send_ready` falls once `fifo_count`=4.
  - The stream is 0x00–0x04 (one byte in the shifter, four in the FIFO). Each subsequent byte is accepted only when ready rises again.
  - Decoded output has no gaps or duplicates.
- Drop on full: with the FIFO full, change `send_data` while `send_ready`=0. Required response: the changed value never appears on the line.
- Reset mid-frame: assert `reset` during DATA bit 3 with 2 bytes queued. Required response:
  - `uart_tx`=1, `fifo_count`=0, `busy`=0 on the next cycle.
  - No further start bit appears until a new push.
- Default parameters: push 0x41. Required response: 7500-cycle frame, with the bit period measured at 750 cycles.
